// File: rtl/z88_extmem_bridge.sv
// Z88 byte bus to external 8/16/32-bit async SRAM/flash bridge with a timed access FSM.
// Optional one-word read buffer: define Z88_EXTMEM_RDBUF_EN.
module z88_extmem_bridge #(
   parameter  int ADDR_W   = 19,
   parameter  int EXT_DW   = 16,
   parameter  int WAIT_CYC = 2,
   localparam int LANE_W   = (EXT_DW == 32) ? 2 : ((EXT_DW == 16) ? 1 : 0),
   localparam int NB       = EXT_DW / 8,
   localparam int LW1      = (LANE_W == 0) ? 1 : LANE_W,
   localparam int MAW      = ADDR_W - LANE_W
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [7:0]        wdata_i,
   output logic [7:0]        rdata_o,
   output logic              ack_o,
   output logic              busy_o,
   output logic              overrun_o,
   output logic [MAW-1:0]    mem_addr_o,
   output logic [EXT_DW-1:0] mem_dq_o,
   output logic              mem_dq_oe_o,
   input  logic [EXT_DW-1:0] mem_dq_i,
   output logic              mem_ce_n_o,
   output logic              mem_oe_n_o,
   output logic              mem_we_n_o,
   output logic [NB-1:0]     mem_be_n_o,
   output logic [1:0]        state_o
);

   // Handshake: req_i is a one-cycle pulse taken only when busy_o=0 and ack_o=0;
   // ack_o is a one-cycle pulse, rdata_o holds from ack until the next ack.
   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [7:0]        wdata_q;
   logic [7:0]        rdata_q, rdata_d;
   logic              overrun_q, overrun_d;
   logic [LW1-1:0]    lane;
   logic [NB-1:0]     be_act;
   logic [7:0]        rd_byte;
   logic              accept, hit, hit_ack_q, last_strobe;

   generate
      if (LANE_W == 0) begin : g_nolane
         assign lane       = '0;
         assign mem_addr_o = addr_q;
      end else begin : g_lane
         assign lane       = addr_q[LANE_W-1:0];
         assign mem_addr_o = addr_q[ADDR_W-1:LANE_W];
      end
   endgenerate

   assign rd_byte     = mem_dq_i[lane*8 +: 8];
   assign mem_dq_o    = {NB{wdata_q}};
   assign busy_o      = (state_q != S_IDLE);
   assign ack_o       = (state_q == S_HOLD) | hit_ack_q;
   assign accept      = req_i & ~busy_o & ~ack_o;
   assign last_strobe = (state_q == S_STROBE) && (cnt_q == 4'd0);
   assign rdata_o     = rdata_q;
   assign overrun_o   = overrun_q;
   assign state_o     = state_q;

   always_comb begin
      be_act = '1;
      for (int i = 0; i < NB; i++) be_act[i] = (lane != LW1'(i));
   end

`ifdef Z88_EXTMEM_RDBUF_EN
   logic [MAW-1:0]    tag_q, word_in;
   logic [EXT_DW-1:0] buf_q;
   logic              bv_q;
   logic [LW1-1:0]    in_lane;

   generate
      if (LANE_W == 0) begin : g_in_nolane
         assign in_lane = '0;
         assign word_in = addr_i;
      end else begin : g_in_lane
         assign in_lane = addr_i[LANE_W-1:0];
         assign word_in = addr_i[ADDR_W-1:LANE_W];
      end
   endgenerate

   assign hit = accept & ~we_i & bv_q & (word_in == tag_q);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         tag_q     <= '0;
         buf_q     <= '0;
         bv_q      <= 1'b0;
         hit_ack_q <= 1'b0;
      end else begin
         hit_ack_q <= hit;
         if (last_strobe && !we_q) begin
            buf_q <= mem_dq_i;
            tag_q <= mem_addr_o;
            bv_q  <= 1'b1;
         end
         // Keep the buffered word coherent with writes that go to the same word.
         if (accept && we_i && bv_q && (word_in == tag_q))
            buf_q[in_lane*8 +: 8] <= wdata_i;
      end
   end
`else
   assign hit       = 1'b0;
   assign hit_ack_q = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rdata_d     = rdata_q;
      overrun_d   = overrun_q | (req_i & (busy_o | ack_o));
      mem_ce_n_o  = 1'b1;
      mem_oe_n_o  = 1'b1;
      mem_we_n_o  = 1'b1;
      mem_dq_oe_o = 1'b0;
      mem_be_n_o  = '1;
      case (state_q)
         S_IDLE: begin
            if (accept && !hit) state_d = S_SETUP;
`ifdef Z88_EXTMEM_RDBUF_EN
            if (hit) rdata_d = buf_q[in_lane*8 +: 8];
`endif
         end
         S_SETUP: begin
            state_d     = S_STROBE;
            cnt_d       = 4'(WAIT_CYC - 1);
            mem_ce_n_o  = 1'b0;
            mem_be_n_o  = be_act;
            mem_oe_n_o  = we_q;
            mem_dq_oe_o = we_q;
         end
         S_STROBE: begin
            mem_ce_n_o  = 1'b0;
            mem_be_n_o  = be_act;
            mem_oe_n_o  = we_q;
            mem_we_n_o  = ~we_q;
            mem_dq_oe_o = we_q;
            if (cnt_q == 4'd0) begin
               state_d = S_HOLD;
               if (!we_q) rdata_d = rd_byte;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_HOLD: begin
            // Strobes released while ce/be/data stay put: write data hold time.
            state_d     = S_IDLE;
            mem_ce_n_o  = 1'b0;
            mem_be_n_o  = be_act;
            mem_dq_oe_o = we_q;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rdata_q   <= '0;
         overrun_q <= 1'b0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rdata_q   <= rdata_d;
         overrun_q <= overrun_d;
         if (accept && !hit) begin
            addr_q  <= addr_i;
            we_q    <= we_i;
            wdata_q <= wdata_i;
         end
      end
   end

endmodule
